// File: rtl/mmio_responder.sv
// mmio_responder: memory-mapped I/O responder for the CPU data-memory side.
// Owns switches, confirm button, LEDs and an 8-digit seven-segment display.
// Register map (offset = addr[7:0]):
//   0x00 RO switches, 0x04 RO button flag (read clears), 0x10 RW LEDs, 0x14 RW seg7 value.
// Build option: define MMIO_DEBOUNCE_EN to filter the button through a
// DEBOUNCE_CYCLES stability counter; otherwise the synchronized level is used directly.
module mmio_responder #(
  parameter logic [31:0] BASE_ADDR       = 32'hFFFF_FC00,
  parameter logic [19:0] DEBOUNCE_CYCLES = 20'd1_000_000,
  parameter logic [16:0] SCAN_DIV        = 17'd100_000
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        MemRead,
  input  logic        MemWrite,
  input  logic [31:0] WriteData,
  output logic        io_sel,
  output logic [31:0] ReadData,
  output logic        rdata_valid,
  output logic        io_err,
  input  logic [15:0] switches,
  input  logic        btn_confirm,
  output logic [15:0] led,
  output logic [7:0]  seg_an,
  output logic [7:0]  seg_cat
);

  localparam logic [7:0] OFF_SW   = 8'h00;
  localparam logic [7:0] OFF_BTN  = 8'h04;
  localparam logic [7:0] OFF_LED  = 8'h10;
  localparam logic [7:0] OFF_SEG7 = 8'h14;

  // Active-low glyphs, {dp,g,f,e,d,c,b,a}; dp is held off.
  function automatic logic [7:0] hex_glyph(input logic [3:0] nib);
    logic [7:0] g;
    unique case (nib)
      4'h0: g = 8'hC0;
      4'h1: g = 8'hF9;
      4'h2: g = 8'hA4;
      4'h3: g = 8'hB0;
      4'h4: g = 8'h99;
      4'h5: g = 8'h92;
      4'h6: g = 8'h82;
      4'h7: g = 8'hF8;
      4'h8: g = 8'h80;
      4'h9: g = 8'h90;
      4'hA: g = 8'h88;
      4'hB: g = 8'h83;
      4'hC: g = 8'hC6;
      4'hD: g = 8'hA1;
      4'hE: g = 8'h86;
      default: g = 8'h8E;
    endcase
    return g;
  endfunction

  // ---------------------------------------------------------------------------
  // Input synchronizers
  // ---------------------------------------------------------------------------
  logic [15:0] sw_meta_q, sw_sync_q;
  logic        btn_meta_q, btn_sync_q;

  // Two-flop synchronizers for the asynchronous board inputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      sw_meta_q  <= '0;
      sw_sync_q  <= '0;
      btn_meta_q <= 1'b0;
      btn_sync_q <= 1'b0;
    end else begin
      sw_meta_q  <= switches;
      sw_sync_q  <= sw_meta_q;
      btn_meta_q <= btn_confirm;
      btn_sync_q <= btn_meta_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Button conditioning
  // ---------------------------------------------------------------------------
  logic btn_level;

`ifdef MMIO_DEBOUNCE_EN
  logic [19:0] db_cnt_q, db_cnt_d;
  logic        btn_db_q, btn_db_d;

  // Accept a new level only after it has persisted for DEBOUNCE_CYCLES cycles.
  always_comb begin
    db_cnt_d = '0;
    btn_db_d = btn_db_q;
    if (btn_sync_q != btn_db_q) begin
      if (db_cnt_q == DEBOUNCE_CYCLES - 20'd1) begin
        btn_db_d = btn_sync_q;
      end else begin
        db_cnt_d = db_cnt_q + 20'd1;
      end
    end
  end

  // Debounce state registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      db_cnt_q <= '0;
      btn_db_q <= 1'b0;
    end else begin
      db_cnt_q <= db_cnt_d;
      btn_db_q <= btn_db_d;
    end
  end

  assign btn_level = btn_db_q;
`else
  logic unused_debounce;
  assign unused_debounce = ^DEBOUNCE_CYCLES;
  assign btn_level       = btn_sync_q;
`endif

  logic btn_prev_q;
  logic btn_rise;

  // Remember the previous conditioned level for edge detection.
  always_ff @(posedge clk) begin
    if (rst) btn_prev_q <= 1'b0;
    else     btn_prev_q <= btn_level;
  end

  assign btn_rise = btn_level & ~btn_prev_q;

  // ---------------------------------------------------------------------------
  // Access decode
  // ---------------------------------------------------------------------------
  logic [7:0] off;
  logic       in_win, aligned, both;
  logic       hit_sw, hit_btn, hit_led, hit_seg, mapped, writable;
  logic       rd_ok, wr_led, wr_seg, acc_err;

  assign in_win  = (addr[31:8] == BASE_ADDR[31:8]);
  assign io_sel  = in_win & (MemRead | MemWrite);
  assign off     = addr[7:0];
  assign aligned = (addr[1:0] == 2'b00);
  assign both    = MemRead & MemWrite;

  // Classify the current access; a simultaneous read/write never gets a read response.
  always_comb begin
    hit_sw   = (off == OFF_SW);
    hit_btn  = (off == OFF_BTN);
    hit_led  = (off == OFF_LED);
    hit_seg  = (off == OFF_SEG7);
    mapped   = hit_sw | hit_btn | hit_led | hit_seg;
    writable = hit_led | hit_seg;
    rd_ok    = in_win & aligned & MemRead & ~MemWrite;
    wr_led   = in_win & aligned & MemWrite & hit_led;
    wr_seg   = in_win & aligned & MemWrite & hit_seg;
    acc_err  = io_sel & (~aligned | both | (MemRead & ~mapped) | (MemWrite & ~writable));
  end

  // ---------------------------------------------------------------------------
  // Registers and read response
  // ---------------------------------------------------------------------------
  logic [15:0] led_q, led_d;
  logic [31:0] seg7_q, seg7_d;
  logic        btn_flag_q, btn_flag_d;
  logic [31:0] rdata_q, rdata_d, rd_mux;
  logic        rvalid_q, err_q;

  // Next-state for the writable registers, button flag and load data.
  always_comb begin
    led_d  = wr_led ? WriteData[15:0] : led_q;
    seg7_d = wr_seg ? WriteData : seg7_q;

    // Set wins over a same-cycle read-clear.
    btn_flag_d = btn_flag_q;
    if (rd_ok && hit_btn) btn_flag_d = 1'b0;
    if (btn_rise)         btn_flag_d = 1'b1;

    rd_mux = '0;
    if (hit_sw)  rd_mux = {16'b0, sw_sync_q};
    if (hit_btn) rd_mux = {31'b0, btn_flag_q};
    if (hit_led) rd_mux = {16'b0, led_q};
    if (hit_seg) rd_mux = seg7_q;

    // Unmapped reads return zero; rd_mux already defaults to zero.
    rdata_d = rd_ok ? rd_mux : rdata_q;
  end

  // Register file, load data and response pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      led_q      <= '0;
      seg7_q     <= '0;
      btn_flag_q <= 1'b0;
      rdata_q    <= '0;
      rvalid_q   <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      led_q      <= led_d;
      seg7_q     <= seg7_d;
      btn_flag_q <= btn_flag_d;
      rdata_q    <= rdata_d;
      rvalid_q   <= rd_ok;
      err_q      <= acc_err;
    end
  end

  assign led         = led_q;
  assign ReadData    = rdata_q;
  assign rdata_valid = rvalid_q;
  assign io_err      = err_q;

  // ---------------------------------------------------------------------------
  // Seven-segment scan
  // ---------------------------------------------------------------------------
  logic [16:0] scan_cnt_q, scan_cnt_d;
  logic [2:0]  digit_q, digit_d;
  logic [7:0]  seg_an_q, seg_an_d, seg_cat_q, seg_cat_d;
  logic [7:0]  an_onehot;
  logic        scan_wrap;

  // Advance the digit on counter wrap; outputs are built from next-state values so
  // anode and cathode move together and a seg7 write shows on its own edge.
  always_comb begin
    scan_wrap  = (scan_cnt_q == SCAN_DIV - 17'd1);
    scan_cnt_d = scan_wrap ? 17'd0 : scan_cnt_q + 17'd1;
    digit_d    = scan_wrap ? digit_q + 3'd1 : digit_q;
    an_onehot  = 8'h01 << digit_d;
    seg_an_d   = ~an_onehot;
    seg_cat_d  = hex_glyph(seg7_d[{digit_d, 2'b00} +: 4]);
  end

  // Scan counter and registered display drive.
  always_ff @(posedge clk) begin
    if (rst) begin
      scan_cnt_q <= '0;
      digit_q    <= '0;
      seg_an_q   <= 8'hFE;
      seg_cat_q  <= 8'hC0;
    end else begin
      scan_cnt_q <= scan_cnt_d;
      digit_q    <= digit_d;
      seg_an_q   <= seg_an_d;
      seg_cat_q  <= seg_cat_d;
    end
  end

  assign seg_an  = seg_an_q;
  assign seg_cat = seg_cat_q;

endmodule

// File: tb/tb_mmio_responder.sv
// Self-checking bench for mmio_responder with small scan/debounce parameters.
module tb_mmio_responder;

  localparam logic [31:0] BASE = 32'hFFFF_FC00;
  localparam int unsigned SCAN = 4;
  localparam int unsigned DEB  = 8;
`ifdef MMIO_DEBOUNCE_EN
  localparam bit DB_EN = 1'b1;
`else
  localparam bit DB_EN = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] addr;
  logic        MemRead, MemWrite;
  logic [31:0] WriteData;
  logic        io_sel;
  logic [31:0] ReadData;
  logic        rdata_valid, io_err;
  logic [15:0] switches;
  logic        btn_confirm;
  logic [15:0] led;
  logic [7:0]  seg_an, seg_cat;

  always #5 clk = ~clk;

  mmio_responder #(
    .BASE_ADDR      (BASE),
    .DEBOUNCE_CYCLES(20'd8),
    .SCAN_DIV       (17'd4)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .addr       (addr),
    .MemRead    (MemRead),
    .MemWrite   (MemWrite),
    .WriteData  (WriteData),
    .io_sel     (io_sel),
    .ReadData   (ReadData),
    .rdata_valid(rdata_valid),
    .io_err     (io_err),
    .switches   (switches),
    .btn_confirm(btn_confirm),
    .led        (led),
    .seg_an     (seg_an),
    .seg_cat    (seg_cat)
  );

  int nvec = 0;
  int nerr = 0;

  // Reference state: edges since reset, LED and seg7 contents.
  int unsigned cyc = 0;
  logic [15:0] led_m;
  logic [31:0] seg7_m;

  always @(posedge clk) begin
    if (rst) cyc <= 0;
    else     cyc <= cyc + 1;
  end

  function automatic logic [7:0] glyph(input logic [3:0] n);
    logic [7:0] tbl [16];
    tbl = '{8'hC0, 8'hF9, 8'hA4, 8'hB0, 8'h99, 8'h92, 8'h82, 8'hF8,
            8'h80, 8'h90, 8'h88, 8'h83, 8'hC6, 8'hA1, 8'h86, 8'h8E};
    return tbl[n];
  endfunction

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One bus cycle; returns 1 time unit after the edge, i.e. inside cycle N+1.
  task automatic access(input logic r, input logic w, input logic [31:0] a,
                        input logic [31:0] d);
    addr = a; MemRead = r; MemWrite = w; WriteData = d;
    @(posedge clk);
    #1;
    MemRead = 1'b0; MemWrite = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick(2);
    nvec++; if (ReadData !== 32'h0) begin nerr++; $display("FAIL reset_rdata got %h want 0", ReadData); end
    nvec++; if (rdata_valid !== 1'b0 || io_err !== 1'b0) begin nerr++; $display("FAIL reset_pulses got %b%b want 00", rdata_valid, io_err); end
    nvec++; if (led !== 16'h0) begin nerr++; $display("FAIL reset_led got %h want 0", led); end
    nvec++; if (seg_an !== 8'hFE || seg_cat !== 8'hC0) begin nerr++; $display("FAIL reset_seg got %h/%h want fe/c0", seg_an, seg_cat); end
    rst = 1'b0;
    led_m = '0; seg7_m = '0;
  endtask

  task automatic test_switches();
    logic [15:0] v;
    for (int i = 0; i < 5; i++) begin
      v = (i == 0) ? 16'hA5C3 : 16'($urandom);
      switches = v;
      tick(3);
      access(1'b1, 1'b0, BASE, 32'h0);
      nvec++; if (rdata_valid !== 1'b1 || ReadData !== {16'h0, v}) begin nerr++; $display("FAIL sw_read got v=%b %h want v=1 %h", rdata_valid, ReadData, {16'h0, v}); end
      nvec++; if (io_err !== 1'b0) begin nerr++; $display("FAIL sw_err got %b want 0", io_err); end
      tick(1);
      nvec++; if (rdata_valid !== 1'b0 || ReadData !== {16'h0, v}) begin nerr++; $display("FAIL sw_hold got v=%b %h want v=0 %h", rdata_valid, ReadData, {16'h0, v}); end
    end
  endtask

  task automatic test_led();
    logic [31:0] w;
    for (int i = 0; i < 5; i++) begin
      w = (i == 0) ? 32'h1234_BEEF : $urandom;
      access(1'b0, 1'b1, BASE + 32'h10, w);
      led_m = w[15:0];
      nvec++; if (led !== led_m || rdata_valid !== 1'b0 || io_err !== 1'b0) begin nerr++; $display("FAIL led_write got %h v=%b e=%b want %h v=0 e=0", led, rdata_valid, io_err, led_m); end
      access(1'b1, 1'b0, BASE + 32'h10, 32'h0);
      nvec++; if (rdata_valid !== 1'b1 || ReadData !== {16'h0, led_m}) begin nerr++; $display("FAIL led_read got %h want %h", ReadData, {16'h0, led_m}); end
    end
  endtask

  task automatic check_display(input string tag);
    int unsigned idx;
    logic [7:0] onehot, exp_an, exp_cat;
    idx     = (cyc / SCAN) % 8;
    onehot  = 8'h01 << idx;
    exp_an  = ~onehot;
    exp_cat = glyph(seg7_m[idx*4 +: 4]);
    nvec++;
    if (seg_an !== exp_an || seg_cat !== exp_cat) begin
      nerr++;
      $display("FAIL %s cyc=%0d got an=%h cat=%h want an=%h cat=%h", tag, cyc, seg_an, seg_cat, exp_an, exp_cat);
    end
  endtask

  task automatic test_seg7();
    access(1'b0, 1'b1, BASE + 32'h14, 32'h0123_4567);
    seg7_m = 32'h0123_4567;
    for (int i = 0; i < 36; i++) begin
      check_display("seg_scan");
      tick(1);
    end
    access(1'b0, 1'b1, BASE + 32'h14, $urandom);
    seg7_m = WriteData;
    for (int i = 0; i < 34; i++) begin
      check_display("seg_rand");
      tick(1);
    end
    access(1'b1, 1'b0, BASE + 32'h14, 32'h0);
    nvec++; if (ReadData !== seg7_m || rdata_valid !== 1'b1) begin nerr++; $display("FAIL seg_read got %h want %h", ReadData, seg7_m); end
  endtask

  task automatic test_io_sel();
    addr = BASE + 32'h10; MemRead = 1'b1; #1;
    nvec++; if (io_sel !== 1'b1) begin nerr++; $display("FAIL io_sel_in got %b want 1", io_sel); end
    MemRead = 1'b0; #1;
    nvec++; if (io_sel !== 1'b0) begin nerr++; $display("FAIL io_sel_idle got %b want 0", io_sel); end
    addr = 32'h0000_1010; MemWrite = 1'b1; WriteData = 32'hFFFF; #1;
    nvec++; if (io_sel !== 1'b0) begin nerr++; $display("FAIL io_sel_out got %b want 0", io_sel); end
    MemWrite = 1'b0;
    access(1'b0, 1'b1, 32'hFFFF_FD10, 32'h0000_5A5A);
    access(1'b1, 1'b0, 32'hFFFF_FD10, 32'h0);
    nvec++; if (led !== led_m || rdata_valid !== 1'b0 || io_err !== 1'b0) begin nerr++; $display("FAIL outside_win got led=%h v=%b e=%b want %h 0 0", led, rdata_valid, io_err, led_m); end
  endtask

  task automatic test_illegal();
    logic [31:0] prev;
    access(1'b1, 1'b0, BASE + 32'h08, 32'h0);
    nvec++; if (io_err !== 1'b1 || rdata_valid !== 1'b1 || ReadData !== 32'h0) begin nerr++; $display("FAIL unmapped_rd got e=%b v=%b %h want 1 1 0", io_err, rdata_valid, ReadData); end
    tick(1);
    nvec++; if (io_err !== 1'b0) begin nerr++; $display("FAIL err_pulse got %b want 0", io_err); end
    access(1'b0, 1'b1, BASE, 32'hFFFF_FFFF);
    nvec++; if (io_err !== 1'b1 || rdata_valid !== 1'b0) begin nerr++; $display("FAIL ro_write got e=%b v=%b want 1 0", io_err, rdata_valid); end
    access(1'b1, 1'b0, BASE, 32'h0);
    nvec++; if (ReadData !== {16'h0, switches}) begin nerr++; $display("FAIL ro_after got %h want %h", ReadData, {16'h0, switches}); end
    prev = ReadData;
    access(1'b1, 1'b0, BASE + 32'h12, 32'h0);
    nvec++; if (io_err !== 1'b1 || rdata_valid !== 1'b0 || ReadData !== prev) begin nerr++; $display("FAIL misalign got e=%b v=%b %h want 1 0 %h", io_err, rdata_valid, ReadData, prev); end
    access(1'b0, 1'b1, BASE + 32'h13, 32'h0000_0F0F);
    nvec++; if (io_err !== 1'b1 || led !== led_m) begin nerr++; $display("FAIL misalign_wr got e=%b led=%h want 1 %h", io_err, led, led_m); end
    access(1'b1, 1'b1, BASE + 32'h10, 32'h0000_C33C);
    led_m = 16'hC33C;
    nvec++; if (io_err !== 1'b1 || rdata_valid !== 1'b0 || led !== led_m) begin nerr++; $display("FAIL rd_wr_both got e=%b v=%b led=%h want 1 0 %h", io_err, rdata_valid, led, led_m); end
  endtask

  task automatic read_btn(input string tag, input logic want);
    access(1'b1, 1'b0, BASE + 32'h04, 32'h0);
    nvec++;
    if (rdata_valid !== 1'b1 || ReadData !== {31'h0, want}) begin
      nerr++;
      $display("FAIL %s got v=%b %h want v=1 %h", tag, rdata_valid, ReadData, {31'h0, want});
    end
  endtask

  task automatic test_button();
    btn_confirm = 1'b0;
    tick(DEB + 6);
    read_btn("btn_idle", 1'b0);
    // Short pulse: rejected only when the filter is present.
    btn_confirm = 1'b1; tick(5);
    btn_confirm = 1'b0; tick(DEB + 8);
    read_btn("btn_short", !DB_EN);
    read_btn("btn_short_clr", 1'b0);
    // Long press is accepted either way.
    btn_confirm = 1'b1; tick(12);
    btn_confirm = 1'b0; tick(DEB + 8);
    read_btn("btn_long", 1'b1);
    read_btn("btn_long_clr", 1'b0);
  endtask

  task automatic test_random();
    int op;
    logic [31:0] w;
    for (int i = 0; i < 40; i++) begin
      op = $urandom_range(0, 4);
      w  = $urandom;
      case (op)
        0: begin access(1'b0, 1'b1, BASE + 32'h10, w); led_m = w[15:0]; end
        1: begin access(1'b0, 1'b1, BASE + 32'h14, w); seg7_m = w; end
        2: begin
          access(1'b1, 1'b0, BASE + 32'h10, 32'h0);
          nvec++; if (ReadData !== {16'h0, led_m}) begin nerr++; $display("FAIL rnd_led got %h want %h", ReadData, {16'h0, led_m}); end
        end
        3: begin
          access(1'b1, 1'b0, BASE + 32'h14, 32'h0);
          nvec++; if (ReadData !== seg7_m) begin nerr++; $display("FAIL rnd_seg got %h want %h", ReadData, seg7_m); end
        end
        default: begin
          switches = w[15:0]; tick(2);
          access(1'b1, 1'b0, BASE, 32'h0);
          nvec++; if (ReadData !== {16'h0, w[15:0]}) begin nerr++; $display("FAIL rnd_sw got %h want %h", ReadData, {16'h0, w[15:0]}); end
        end
      endcase
      nvec++; if (led !== led_m) begin nerr++; $display("FAIL rnd_ledpin got %h want %h", led, led_m); end
      check_display("rnd_seg_pins");
    end
  endtask

  task automatic test_reset_mid();
    access(1'b0, 1'b1, BASE + 32'h10, 32'h0000_BEEF);
    nvec++; if (led !== 16'hBEEF) begin nerr++; $display("FAIL pre_rst_led got %h want beef", led); end
    tick(5);
    rst = 1'b1; addr = BASE; MemRead = 1'b1;
    @(posedge clk); #1;
    rst = 1'b0; MemRead = 1'b0;
    led_m = '0; seg7_m = '0;
    nvec++; if (led !== 16'h0 || seg_an !== 8'hFE || rdata_valid !== 1'b0) begin nerr++; $display("FAIL mid_rst got led=%h an=%h v=%b want 0 fe 0", led, seg_an, rdata_valid); end
    tick(1);
    nvec++; if (rdata_valid !== 1'b0) begin nerr++; $display("FAIL mid_rst_late got v=%b want 0", rdata_valid); end
    check_display("post_rst_seg");
  endtask

  initial begin
    rst = 1'b1; addr = '0; MemRead = 1'b0; MemWrite = 1'b0; WriteData = '0;
    switches = '0; btn_confirm = 1'b0;
    test_reset();
    test_switches();
    test_led();
    test_seg7();
    test_io_sel();
    test_illegal();
    test_button();
    test_random();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
    $finish;
  end

endmodule

// File: doc/mmio_responder.md
Name: mmio_responder

Overview:
- Memory-mapped I/O responder on the CPU data-memory side. Answers CPU loads and stores that fall in the I/O window.
- Owns the board peripherals: 16 switches, one confirm button, 16 LEDs, and an 8-digit seven-segment display.
- Sits beside data memory. Its read data is muxed into the load path whenever io_sel is high.

Parameters:
- BASE_ADDR, 32'hFFFF_FC00, base of the I/O window; decode compares addr[31:8] with BASE_ADDR[31:8].
- DEBOUNCE_CYCLES, 20'd1_000_000, number of stable cycles the button needs before its level is accepted.
- SCAN_DIV, 17'd100_000, number of clk cycles each seven-segment digit is lit.

Ports:
- clk  input  1  system clock
- rst  input  1  synchronous reset, active-high
- addr  input  32  CPU byte address
- MemRead  input  1  load strobe, one cycle per access
- MemWrite  input  1  store strobe, one cycle per access
- WriteData  input  32  store data
- io_sel  output  1  combinational: addr is in the window and (MemRead or MemWrite) is high
- ReadData  output  32  registered load data
- rdata_valid  output  1  one-cycle pulse when ReadData is valid
- io_err  output  1  one-cycle pulse on an illegal access
- switches  input  16  raw switch levels, asynchronous
- btn_confirm  input  1  raw button, asynchronous, active-high
- led  output  16  LED drive
- seg_an  output  8  digit enables, active-low
- seg_cat  output  8  segments {dp,g,f,e,d,c,b,a}, active-low; dp always 1

Behaviour:
- Reset: ReadData=0, rdata_valid=0, io_err=0, led=0, seg7 register=0, btn_flag=0, scan counter=0, digit index=0, seg_an=8'hFE, seg_cat shows digit 0 with value 0 (8'hC0). Debounce state and synchronizers are cleared.
- switches and btn_confirm each pass through a 2-flop synchronizer. The switches are sampled at the second flop.
- Register map (offset = addr[7:0]):
  - 0x00 RO: {16'b0, switches_sync}.
  - 0x04 RO: {31'b0, btn_flag}. A read clears btn_flag.
  - 0x10 RW: LED, stored as WriteData[15:0]; reads back {16'b0, led}.
  - 0x14 RW: seg7 value, 32 bits, displayed as 8 hex digits.
- Read latency is 1 cycle. Cycle N has MemRead=1 with a valid window address. In cycle N+1, ReadData holds the value and rdata_valid=1. ReadData holds that value until the next read.
- Writes take effect at the cycle-N edge. There is no response pulse.
- Illegal access, each producing io_err=1 in N+1:
  - Unmapped offset: reads return 0 with rdata_valid=1; writes are ignored.
  - Write to an RO offset: ignored.
  - Misaligned access (addr[1:0]!=0): ignored, no rdata_valid.
  - MemRead and MemWrite both high: the write is performed if legal, no read response is given, and io_err=1.
- Accesses outside the window are ignored, with io_sel=0.
- Button:
  - The debounced level changes only after the synchronized input has differed from it for DEBOUNCE_CYCLES consecutive cycles. Any bounce restarts the counter.
  - A rising edge of the debounced level sets btn_flag.
  - If a set and a read-clear happen in the same cycle, the set wins and btn_flag stays 1. The read still returns the old value.
- Seven-segment:
  - The scan counter counts 0..SCAN_DIV-1. On wrap, the digit index advances 0..7, then back to 0.
  - seg_an has a single 0 at the bit for the digit index.
  - seg_cat decodes nibble seg7[4*idx+3 : 4*idx] to hex glyphs 0-F.
  - seg_an and seg_cat are registered, and both change on the same edge.
- Reset asserted in the middle of debounce or scan returns everything to its reset value on the next edge. A read pending when reset is asserted yields no rdata_valid.

Optional Feature:
- Macro: MMIO_DEBOUNCE_EN.
- Defined: the button uses the debounce filter described above.
- Undefined: the debounced level equals the synchronized level. The counter logic is omitted, and btn_flag is set one cycle after a synchronized rising edge. DEBOUNCE_CYCLES is unused.

Test Plan:
- Reset, then hold switches=16'hA5C3; read addr 32'hFFFF_FC00 -> next cycle ReadData=32'h0000_A5C3, rdata_valid=1 for exactly one cycle.
- Write 32'h1234_BEEF to 0xFFFF_FC10, then read it back -> led=16'hBEEF after the write edge; read returns 32'h0000_BEEF.
- Write 32'h0123_4567 to 0xFFFF_FC14 with SCAN_DIV=4 -> digit 0 shows '7' (seg_cat=8'hF8, seg_an=8'hFE); after 4 cycles digit 1 shows '6' (seg_an=8'hFD); index wraps to 0 after 32 cycles.
- With DEBOUNCE_CYCLES=8 and MMIO_DEBOUNCE_EN defined, pulse the button high for 5 cycles, then hold it high for 12 cycles -> btn_flag stays 0 after the 5-cycle pulse; it sets after the held press; reading 0xFFFF_FC04 returns 1, a second read returns 0.
- Read 0xFFFF_FC08, write 0xFFFF_FC00, then access 0xFFFF_FC12 -> io_err pulse for each. The 0xFFFF_FC08 read returns 0 with rdata_valid; the RO write leaves switch reads unchanged; 0xFFFF_FC12 gives no rdata_valid.
- Assert rst for one cycle after the LED write 16'hBEEF, with a read issued in the same cycle -> led=0, seg_an=8'hFE, no rdata_valid.
